poly_seq_ctrl: RTL and testbench
================================

Name: poly_seq_ctrl

Overview:
Programmable sequencer for the 4-register (A, B, C, X) add/multiply ALU datapath.
- Replaces the hard-wired button-driven FSM with a valid/ready operand-load handshake, a start/done command handshake and a 4-entry microcode ROM selected by mode.
- Drives the datapath control bus (ld_a/b/c/x/r, ld_alu_out, alu_select_a/b, alu_op) directly; data_in goes straight from the operand source to the datapath.

Parameters:
MAX_STEPS, 8, microcode depth per mode; step counter is clog2(MAX_STEPS) bits
MODE_W, 2, width of mode input

Ports:
clk  in  1  system clock; all state on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  command request; accepted only when IDLE
mode  in  MODE_W  program select, sampled on start accept
abort  in  1  synchronous cancel of any in-flight command
in_valid  in  1  operand on data_in valid this cycle
in_ready  out  1  controller ready to accept an operand
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, result register written
err  out  1  one-cycle pulse, start with illegal mode rejected
ld_a, ld_b, ld_c, ld_x, ld_r  out  1 each  datapath register loads
ld_alu_out  out  1  dest register takes ALU result instead of data_in
alu_select_a, alu_select_b  out  2 each  0=A 1=B 2=C 3=X
alu_op  out  1  0=add 1=multiply

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE, mode_q=0, operand idx=0, step=0. All outputs 0 from the next cycle. Reset mid-command discards the command with no done pulse.
- States: IDLE, LOAD, EXEC, DONE.
- IDLE:
  - start=1 with mode in {0,1,2}: capture mode_q, go to LOAD, idx=0.
  - start=1 with mode=3: stay IDLE, err=1 next cycle.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, assert (combinationally, same cycle) the load for idx in the order 0=A, 1=B, 2=C, 3=X, with ld_alu_out=0; idx++.
  - Accept at idx=3 goes to EXEC with step=0. No beat means no load and idx holds.
- EXEC: one microcode step per cycle. Outputs are decoded from ROM[mode_q][step]. Step fields: dest (A/B/X/R), src_a, src_b, op, last.
  - Dest A/B/X: ld_<dest>=1, ld_alu_out=1.
  - Dest R: ld_r=1, ld_alu_out=0.
  - last=1 goes to DONE, else step++.
  - C is never a destination.
- DONE: done=1 for exactly one cycle, all loads 0, then IDLE. A start in the DONE cycle is ignored. The earliest new start is accepted in IDLE.
- Microcode (arithmetic mod 256, set by the datapath's 8-bit registers):
  - mode 0, A*X^2+B*X+C: A<-A*X; A<-A*X; B<-B*X; A<-A+B; R<-A+C.
  - mode 1, A*X+B: A<-A*X; R<-A+B.
  - mode 2, (A+B)*(C+X): A<-A+B; X<-C+X; R<-A*X.
- Latency: start accept to done pulse = 1 + 4 load beats (minimum) + N steps + 1 cycle. Mode 0 with back-to-back valid: start at cycle 0, done high at cycle 10.
- abort=1 in LOAD/EXEC/DONE:
  - Gates every ld_* and done to 0 combinationally in that cycle.
  - Next state is IDLE with no done pulse.
  - In IDLE, abort is ignored; abort wins over a simultaneous start.
- start while busy: ignored, no err.
- mode changes after accept have no effect until the next accept.

Optional Feature:
POLY_SEQ_PERF_EN:
- Defined: adds output last_cycles [7:0]. It counts cycles from the start-accept cycle through the DONE cycle inclusive, saturating at 255. It updates on DONE, holds otherwise, resets to 0, and is unchanged by abort.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package poly_seq_pkg holds:
  - state encoding
  - select codes (SEL_A..SEL_X)
  - op codes (OP_ADD, OP_MUL)
  - dest codes
  - microcode step struct/width constants
  - mode constants
- Sub-module poly_seq_rom: combinational (mode, step) -> step word. Unused entries return last=1 with dest=R.

Test Plan:
- Mode 0 with datapath, A=2 B=3 C=4 X=5, back-to-back valid -> data_result=0x45 (69), done one pulse at cycle 10, busy cycles 1-10.
- Mode 1, A=2 B=3 X=5 -> 0x0D. Mode 2, A=2 B=3 C=4 X=5 -> 0x2D. Each has exactly one done pulse.
- Mode 0, A=1 B=0 C=0 X=16 -> 0x00 (256 wraps). in_valid toggled 1/0 during LOAD -> loads only on valid cycles, idx order preserved.
- start with mode=3 -> err one cycle, busy stays 0, no ld_* asserted. start pulsed during EXEC -> ignored.
- abort on EXEC step 2 of mode 0 -> ld_b=0 that cycle, IDLE next, no done, data_result unchanged. resetn=0 mid-LOAD -> IDLE, in_ready=0 next cycle.
- POLY_SEQ_PERF_EN defined, mode 1 with one idle valid gap -> last_cycles=9.

Source files
------------

// File: rtl/poly_seq_pkg.sv
// Shared encodings for the poly_seq sequencer: FSM states, ALU select/op codes,
// microcode destination codes, the microcode step word and the program (mode) numbers.
package poly_seq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_DONE} state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // C is an operand-only register, so it has no destination code.
    typedef enum logic [1:0] {DST_A, DST_B, DST_X, DST_R} dest_t;

    typedef struct packed {
        dest_t      dest;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       op;
        logic       last;
    } step_t;

    localparam int STEP_W = $bits(step_t);

    localparam int MODE_POLY2 = 0;  // A*X^2 + B*X + C
    localparam int MODE_LIN   = 1;  // A*X + B
    localparam int MODE_PROD  = 2;  // (A+B)*(C+X)
    localparam int NUM_MODES  = 3;

    function automatic step_t mk_step(input dest_t d, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic op,
                                      input logic last);
        step_t s;
        s.dest  = d;
        s.src_a = sa;
        s.src_b = sb;
        s.op    = op;
        s.last  = last;
        return s;
    endfunction

endpackage

// File: rtl/poly_seq_rom.sv
// Combinational microcode store: (mode, step) -> step word.
// Any entry outside a program terminates it by writing R.
module poly_seq_rom
    import poly_seq_pkg::*;
#(
    parameter int MODE_W  = 2,
    parameter int STEP_CW = 3
) (
    input  logic [MODE_W-1:0]  i_mode,
    input  logic [STEP_CW-1:0] i_step,
    output step_t              o_word
);

    always_comb begin
        o_word = mk_step(DST_R, SEL_A, SEL_A, OP_ADD, 1'b1);
        case (int'(i_mode))
            MODE_POLY2: begin
                case (int'(i_step))
                    0:       o_word = mk_step(DST_A, SEL_A, SEL_X, OP_MUL, 1'b0);
                    1:       o_word = mk_step(DST_A, SEL_A, SEL_X, OP_MUL, 1'b0);
                    2:       o_word = mk_step(DST_B, SEL_B, SEL_X, OP_MUL, 1'b0);
                    3:       o_word = mk_step(DST_A, SEL_A, SEL_B, OP_ADD, 1'b0);
                    4:       o_word = mk_step(DST_R, SEL_A, SEL_C, OP_ADD, 1'b1);
                    default: ;
                endcase
            end
            MODE_LIN: begin
                case (int'(i_step))
                    0:       o_word = mk_step(DST_A, SEL_A, SEL_X, OP_MUL, 1'b0);
                    1:       o_word = mk_step(DST_R, SEL_A, SEL_B, OP_ADD, 1'b1);
                    default: ;
                endcase
            end
            MODE_PROD: begin
                case (int'(i_step))
                    0:       o_word = mk_step(DST_A, SEL_A, SEL_B, OP_ADD, 1'b0);
                    1:       o_word = mk_step(DST_X, SEL_C, SEL_X, OP_ADD, 1'b0);
                    2:       o_word = mk_step(DST_R, SEL_A, SEL_X, OP_MUL, 1'b1);
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/poly_seq_ctrl.sv
// Microcoded sequencer for the A/B/C/X add/multiply datapath: operand load handshake,
// start/done command handshake. Optional cycle counter under POLY_SEQ_PERF_EN.
module poly_seq_ctrl
    import poly_seq_pkg::*;
#(
    parameter int MAX_STEPS = 8,
    parameter int MODE_W    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ld_a,
    output logic              ld_b,
    output logic              ld_c,
    output logic              ld_x,
    output logic              ld_r,
    output logic              ld_alu_out,
    output logic [1:0]        alu_select_a,
    output logic [1:0]        alu_select_b,
    output logic              alu_op
`ifdef POLY_SEQ_PERF_EN
    ,
    output logic [7:0]        last_cycles
`endif
);

    localparam int STEP_CW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MODE_W-1:0]  r_mode;
    logic [1:0]         r_idx;
    logic [STEP_CW-1:0] r_step;
    logic               r_err;
    step_t              w_word;
    logic               w_start_ok;
    logic               w_illegal;
    logic               w_accept;
    logic               w_beat;

    poly_seq_rom #(
        .MODE_W  (MODE_W),
        .STEP_CW (STEP_CW)
    ) u_rom (
        .i_mode (r_mode),
        .i_step (r_step),
        .o_word (w_word)
    );

    // abort takes priority over a start arriving in the same IDLE cycle
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_illegal  = (int'(mode) >= NUM_MODES);
    assign w_accept   = w_start_ok && !w_illegal;
    assign w_beat     = (r_state == ST_LOAD) && in_valid && !abort;
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_mode  <= '0;
            r_idx   <= '0;
            r_step  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_start_ok && w_illegal;
            if (w_accept) begin
                r_mode <= mode;
                r_idx  <= '0;
            end else if (w_beat) begin
                r_idx <= r_idx + 2'd1;
            end
            r_step <= (r_state == ST_EXEC) ? r_step + STEP_CW'(1) : '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        done         = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_c         = 1'b0;
        ld_x         = 1'b0;
        ld_r         = 1'b0;
        ld_alu_out   = 1'b0;
        alu_select_a = SEL_A;
        alu_select_b = SEL_A;
        alu_op       = OP_ADD;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (r_idx)
                        2'd0: ld_a = 1'b1;
                        2'd1: ld_b = 1'b1;
                        2'd2: ld_c = 1'b1;
                        2'd3: ld_x = 1'b1;
                        default: ;
                    endcase
                    if (r_idx == 2'd3) w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_select_a = w_word.src_a;
                alu_select_b = w_word.src_b;
                alu_op       = w_word.op;
                case (w_word.dest)
                    DST_A: begin ld_a = 1'b1; ld_alu_out = 1'b1; end
                    DST_B: begin ld_b = 1'b1; ld_alu_out = 1'b1; end
                    DST_X: begin ld_x = 1'b1; ld_alu_out = 1'b1; end
                    DST_R: ld_r = 1'b1;
                    default: ;
                endcase
                if (w_word.last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            in_ready    = 1'b0;
            done        = 1'b0;
            ld_a        = 1'b0;
            ld_b        = 1'b0;
            ld_c        = 1'b0;
            ld_x        = 1'b0;
            ld_r        = 1'b0;
            ld_alu_out  = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

`ifdef POLY_SEQ_PERF_EN
    logic [7:0] r_cyc;
    logic [7:0] r_last;

    // r_cyc already includes the accept cycle, so DONE adds one more
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cyc  <= 8'd0;
            r_last <= 8'd0;
        end else begin
            if (w_accept) begin
                r_cyc <= 8'd1;
            end else if (busy && (r_cyc != 8'hFF)) begin
                r_cyc <= r_cyc + 8'd1;
            end
            if ((r_state == ST_DONE) && !abort) begin
                r_last <= (r_cyc == 8'hFF) ? 8'hFF : r_cyc + 8'd1;
            end
        end
    end

    assign last_cycles = r_last;
`endif

endmodule

// File: tb/tb_poly_seq_ctrl.sv
// Directed bench for poly_seq_ctrl with a behavioural 8-bit A/B/C/X/R datapath
// driven by the controller's load/select bus.
module tb_poly_seq_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] mode;
    logic       abort;
    logic       in_valid;
    logic [7:0] data_in;
    logic       in_ready, busy, done, err;
    logic       ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out;
    logic [1:0] alu_select_a, alu_select_b;
    logic       alu_op;
`ifdef POLY_SEQ_PERF_EN
    logic [7:0] last_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    poly_seq_ctrl #(.MAX_STEPS(8), .MODE_W(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .mode         (mode),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ld_a         (ld_a),
        .ld_b         (ld_b),
        .ld_c         (ld_c),
        .ld_x         (ld_x),
        .ld_r         (ld_r),
        .ld_alu_out   (ld_alu_out),
        .alu_select_a (alu_select_a),
        .alu_select_b (alu_select_b),
        .alu_op       (alu_op)
`ifdef POLY_SEQ_PERF_EN
        ,
        .last_cycles  (last_cycles)
`endif
    );

    // Behavioural datapath
    logic [7:0] rA, rB, rC, rX, rR;
    logic [7:0] opa, opb, alu;
    logic [5:0] lds;

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c,
                                        input logic [7:0] x);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return x;
        endcase
    endfunction

    assign opa = pick(alu_select_a, rA, rB, rC, rX);
    assign opb = pick(alu_select_b, rA, rB, rC, rX);
    assign alu = alu_op ? 8'(opa * opb) : 8'(opa + opb);
    assign lds = {ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out};

    always @(posedge clk) begin
        if (ld_a) rA <= ld_alu_out ? alu : data_in;
        if (ld_b) rB <= ld_alu_out ? alu : data_in;
        if (ld_c) rC <= ld_alu_out ? alu : data_in;
        if (ld_x) rX <= ld_alu_out ? alu : data_in;
        if (ld_r) rR <= alu;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // gap: 0 = valid every cycle, 1 = one idle cycle at cycle 2, 2 = valid on odd cycles only
    typedef struct {
        logic [1:0] mode;
        logic [7:0] a, b, c, x;
        int         gap;
        int         poke_cyc;
        logic [1:0] poke_mode;
        int         abort_cyc;
        logic [7:0] exp_r;
        int         exp_done;
        int         exp_ndone;
        int         exp_busy;
        logic [7:0] exp_perf;
    } vec_t;

    vec_t tbl[7];

    // Call at posedge+1; the calling cycle is cycle 0 (start presented).
    task automatic run_cmd(input vec_t v, output int done_cyc, output int ndone,
                           output int nbusy, output int stray, output int nerr);
        logic [7:0] ops[4];
        int idx;
        int cyc;
        ops[0] = v.a; ops[1] = v.b; ops[2] = v.c; ops[3] = v.x;
        idx = 0; done_cyc = -1; ndone = 0; nbusy = 0; stray = 0; nerr = 0;
        start = 1'b1; mode = v.mode; in_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            in_valid = (idx < 4) && !(v.gap == 1 && cyc == 2) && !(v.gap == 2 && (cyc % 2) == 0);
            data_in  = (idx < 4) ? ops[idx] : 8'h00;
            start    = (cyc == v.poke_cyc);
            if (cyc == v.poke_cyc) mode = v.poke_mode;
            abort    = (cyc == v.abort_cyc);
            @(negedge clk);
            if (busy) nbusy++;
            if (err) nerr++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if ((ld_a | ld_b | ld_c | ld_x) && !ld_alu_out && !in_valid) stray++;
            if (abort && ((|lds) || done)) stray++;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
            if ((done_cyc >= 0 && cyc > done_cyc + 2) || (v.abort_cyc > 0 && cyc > v.abort_cyc + 3)) break;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        int dc, nd, nb, st, ne;
        resetn = 1'b0; start = 1'b0; mode = 2'd0; abort = 1'b0; in_valid = 1'b0; data_in = 8'h00;

        tbl[0] = '{2'd0, 8'd2, 8'd3, 8'd4, 8'd5, 0, 0, 2'd0, 0, 8'h45, 10, 1, 10, 8'd11};
        tbl[1] = '{2'd0, 8'd1, 8'd1, 8'd1, 8'd1, 0, 0, 2'd0, 7, 8'h45, -1, 0, 7, 8'd11};
        tbl[2] = '{2'd1, 8'd2, 8'd3, 8'd4, 8'd5, 0, 0, 2'd0, 0, 8'h0D, 7, 1, 7, 8'd8};
        tbl[3] = '{2'd2, 8'd2, 8'd3, 8'd4, 8'd5, 0, 8, 2'd1, 0, 8'h2D, 8, 1, 8, 8'd9};
        tbl[4] = '{2'd0, 8'd1, 8'd0, 8'd0, 8'd16, 2, 0, 2'd0, 0, 8'h00, 13, 1, 13, 8'd14};
        tbl[5] = '{2'd1, 8'd2, 8'd3, 8'd4, 8'd5, 1, 0, 2'd0, 0, 8'h0D, 8, 1, 8, 8'd9};
        tbl[6] = '{2'd0, 8'd2, 8'd3, 8'd4, 8'd5, 0, 6, 2'd3, 0, 8'h45, 10, 1, 10, 8'd11};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", {busy, in_ready, done, err, lds, alu_select_a, alu_select_b, alu_op}, '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Illegal mode: err pulse, stays idle
        start = 1'b1; mode = 2'd3;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'd0;
        @(negedge clk);
        chk("err_pulse", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_loads", lds, 6'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_clear", {err, busy}, 2'b00);
        @(posedge clk); #1;

        // Reset in the middle of operand loading
        start = 1'b1; mode = 2'd0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; data_in = 8'hAA;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ready", in_ready, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_cmd(tbl[i], dc, nd, nb, st, ne);
            chk($sformatf("v%0d_result", i), rR, tbl[i].exp_r);
            chk($sformatf("v%0d_done_cycle", i), dc, tbl[i].exp_done);
            chk($sformatf("v%0d_done_count", i), nd, tbl[i].exp_ndone);
            chk($sformatf("v%0d_busy_cycles", i), nb, tbl[i].exp_busy);
            chk($sformatf("v%0d_stray_loads", i), st, 0);
            chk($sformatf("v%0d_err_count", i), ne, 0);
`ifdef POLY_SEQ_PERF_EN
            chk($sformatf("v%0d_last_cycles", i), last_cycles, tbl[i].exp_perf);
`endif
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
